// File: rtl/cpu_sequencer_pkg.sv
// Shared codes for the multicycle sequencer and the control decoder.
// FETCH/EXEC1/EXEC2 keep their original encodings. The new states use the unused codes.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC1 = 3'd1,
        EXEC2 = 3'd2,
        IDLE  = 3'd3,
        HALT  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;

    // Returns 1 for the states where the bus or the mul/div unit can hold the sequencer.
    function automatic logic is_exec_state(input state_t s);
        return (s == FETCH) || (s == EXEC1) || (s == EXEC2);
    endfunction

endpackage

// File: rtl/cpu_sequencer_stall_watchdog.sv
// Counts consecutive stalled cycles. Trips when another stall arrives after WAIT_LIMIT
// stalled cycles have already been counted.
module cpu_sequencer_stall_watchdog #(
    parameter int WAIT_LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_i,
    input  logic clear_i,
    output logic trip_o
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign trip_o = stall_i & (cnt_q == LIMIT);

    // NOTE: assign a default first so that every path writes cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !stall_i)
            cnt_d = '0;
        else if (cnt_q != LIMIT)
            cnt_d = cnt_q + CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so that all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle FETCH -> EXEC1 -> EXEC2 sequencer. It holds on bus waitrequest and mul/div busy,
// detects a jump to HALT_ADDR, and drops into FAULT when the bus-stall watchdog trips.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR  = HALT_ADDR_DEFAULT,
    parameter int          WAIT_LIMIT = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             waitrequest_i,
    input  logic             mem_access_i,
    input  logic             md_busy_i,
    input  logic [31:0]      pc_next_i,
    output state_t           state_o,
    output logic             stall_o,
    output logic             active_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] instr_count_o
);

    state_t           state_q, state_d;
    logic             active_q, active_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall;
    logic             trip;
    logic             wd_clear;

    // The stall term is kept in its own process so that the watchdog trip path has no loop.
    always_comb begin
        stall = 1'b0;
        if (is_exec_state(state_q))
            stall = (mem_access_i & waitrequest_i) | ((state_q == EXEC2) & md_busy_i);
    end

    assign wd_clear = (state_d != state_q);

    cpu_sequencer_stall_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .stall_i (stall),
        .clear_i (wd_clear),
        .trip_o  (trip)
    );

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        fault_d  = fault_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                state_d  = FETCH;
                active_d = 1'b1;
            end
            FETCH, EXEC1, EXEC2: begin
                if (trip) begin
                    state_d  = FAULT;
                    fault_d  = 1'b1;
                    active_d = 1'b0;
                end else if (!stall) begin
                    if (state_q == FETCH) begin
                        state_d = EXEC1;
                    end else if (state_q == EXEC1) begin
                        state_d = EXEC2;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                        if (pc_next_i == HALT_ADDR) begin
                            state_d  = HALT;
                            active_d = 1'b0;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            HALT, FAULT: ;
            default: begin
                state_d  = FAULT;
                fault_d  = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            fault_q  <= fault_d;
            count_q  <= count_d;
        end
    end

    assign state_o       = state_q;
    assign stall_o       = stall;
    assign active_o      = active_q;
    assign fault_o       = fault_q;
    assign instr_count_o = count_q;

endmodule
